// File: rtl/subtractor_8bits_serial_pkg.sv
// Shared encodings and defaults for the bit-serial subtractor.
package subtractor_8bits_serial_pkg;
  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = STATE_IDLE,
    S_RUN  = STATE_RUN,
    S_DONE = STATE_DONE
  } state_t;
endpackage

// File: rtl/subtractor_8bits_serial_full_subtractor.sv
// One-bit full subtractor cell: diff = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/subtractor_8bits_serial.sv
// Bit-serial subtractor: d = a - b over WIDTH cycles, LSB first, with
// a start/busy/done handshake.
module subtractor_8bits_serial
  import subtractor_8bits_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             diff_bit, br_next, last;

  full_subtractor u_fs (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (br),
    .diff (diff_bit),
    .bout (br_next)
  );

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          sa  <= a;
          sb  <= b;
          br  <= 1'b0;
          cnt <= '0;
        end
        S_RUN: begin
          res <= {diff_bit, res[WIDTH-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_next;
          cnt <= cnt + CW'(1);
          // Publish only on the final bit so d/borrow hold between results.
          if (last) begin
            d      <= {diff_bit, res[WIDTH-1:1]};
            borrow <= br_next;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_subtractor_8bits_serial.sv
// Directed and random checks of the bit-serial subtractor.
module tb_subtractor_8bits_serial;
  logic       clk, rst, start;
  logic [7:0] a, b;
  logic       busy, done, borrow;
  logic [7:0] d;

  int checks = 0;
  int failures = 0;
  int overlap = 0;

  subtractor_8bits_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .d(d), .borrow(borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Returns one negedge after the accepting edge.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb);
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb;
  endtask

  task automatic wait_done(output int e, output int bc, output int hb);
    logic [7:0] held_d;
    logic       held_b;
    held_d = d; held_b = borrow;
    e = 0; bc = 0; hb = 0;
    while (!done && e < 20) begin
      if (busy) bc++;
      if (d !== held_d || borrow !== held_b) hb++;
      @(negedge clk);
      e++;
    end
    if (done && busy) overlap++;
  endtask

  task automatic op(input logic [7:0] ta, input logic [7:0] tb,
                    input logic [7:0] ed, input logic eb);
    int e, bc, hb;
    start_op(ta, tb);
    wait_done(e, bc, hb);
    chk("latency", e, 8);
    chk("busy_len", bc, 8);
    chk("hold", hb, 0);
    chk("d", 32'(d), 32'(ed));
    chk("borrow", 32'(borrow), 32'(eb));
  endtask

  initial begin
    int e, bc, hb, nd, t, t1, t2;
    logic [7:0] d1, d2;
    logic       b1, b2;
    logic [7:0] ta, tb;
    logic [8:0] diff;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_d", 32'(d), 0);
    chk("rst_borrow", 32'(borrow), 0);
    @(negedge clk); rst = 1'b0;

    op(8'h01, 8'h00, 8'h01, 1'b0);
    op(8'hFB, 8'hFC, 8'hFF, 1'b1);
    op(8'hFF, 8'hFC, 8'h03, 1'b0);
    op(8'hFF, 8'hFF, 8'h00, 1'b0);
    op(8'h00, 8'h01, 8'hFF, 1'b1);
    op(8'h80, 8'h7F, 8'h01, 1'b0);
    op(8'h00, 8'hFF, 8'h01, 1'b1);
    op(8'hA5, 8'h00, 8'hA5, 1'b0);

    // Start pulsed 3 cycles into RUN must be ignored.
    start_op(8'h55, 8'h22);
    @(negedge clk); @(negedge clk);
    a = 8'h01; b = 8'h02; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(e, bc, hb);
    chk("ign_latency", e, 5);
    chk("ign_d", 32'(d), 'h33);
    chk("ign_borrow", 32'(borrow), 0);
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("ign_no_extra_done", nd, 0);

    // Start held high: back-to-back operations every 10 cycles.
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    nd = 0; t1 = 0; t2 = 0; d1 = '0; d2 = '0; b1 = 1'b0; b2 = 1'b0;
    for (t = 0; t < 40 && nd < 2; t++) begin
      @(negedge clk);
      if (done) begin
        if (nd == 0) begin
          t1 = t; d1 = d; b1 = borrow;
          a = 8'h30; b = 8'h05;
        end else begin
          t2 = t; d2 = d; b2 = borrow;
          start = 1'b0;
        end
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_count", nd, 2);
    chk("b2b_period", t2 - t1, 10);
    chk("b2b_d1", 32'(d1), 'hF0);
    chk("b2b_b1", 32'(b1), 1);
    chk("b2b_d2", 32'(d2), 'h2B);
    chk("b2b_b2", 32'(b2), 0);
    @(negedge clk); @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    start_op(8'h9A, 8'h11);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_d", 32'(d), 0);
    chk("mid_rst_borrow", 32'(borrow), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("post_rst_idle", nd, 0);
    op(8'hC3, 8'h3C, 8'h87, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ta = 8'($urandom_range(0, 255));
      tb = 8'($urandom_range(0, 255));
      diff = {1'b0, ta} - {1'b0, tb};
      start_op(ta, tb);
      wait_done(e, bc, hb);
      chk("rnd_result", 32'({borrow, d}), 32'(diff));
    end
    chk("done_busy_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  always @(negedge clk) if (done && busy) overlap++;
endmodule
